// File: rtl/bsc_chain.sv
// bsc_chain -- parametrised boundary-scan data register.
//
// WIDTH boundary-scan cells chained SI -> SO (bit 0 is nearest SO), each
// with a capture/shift flop (C) and an UpdateDR-gated update flop (U).
// Sits between device pins/core and the TAP; strobes come from the TAP
// controller and are level-sampled on every TCK rising edge.
//
// Ports:
//   TCK        test clock, all state on posedge
//   RST        synchronous reset, active-high (overrides every strobe)
//   PI         parallel inputs (pin/core side)
//   SI         serial in (TDI side)
//   ShiftDR    shift strobe: C <= {SI, C[WIDTH-1:1]}
//   CaptureDR  capture strobe: C <= PI (wins over ShiftDR)
//   UpdateDR   update strobe: U <= C (pre-edge value)
//   mode       0 = functional (PO = PI), 1 = test (PO = U)
//   SO         serial out = C[0]
//   PO         parallel outputs
//   ShiftCnt   shifts since last capture, saturating
//   c_q, u_q   capture and update stage contents, for observation only
//
// Build option:
//   BSC_CAPTURE_PO_EN  when defined, cell k captures PO[k] instead of PI[k]
//                      wherever OUT_MASK[k] = 1. Undefined: all cells
//                      capture PI and OUT_MASK has no effect.

module bsc_cell #(
    parameter logic SAFE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic cap,
    input  logic shift,
    input  logic upd,
    input  logic cap_d,   // value loaded on capture
    input  logic ser_in,  // upstream neighbour (or SI for the last cell)
    output logic c,
    output logic u
);
    always_ff @(posedge clk) begin
        if (rst)        c <= 1'b0;
        else if (cap)   c <= cap_d;
        else if (shift) c <= ser_in;
    end

    // U samples the pre-edge C, so an update on a shift/capture edge still
    // publishes the value that was sitting in the chain before that edge.
    always_ff @(posedge clk) begin
        if (rst)      u <= SAFE;
        else if (upd) u <= c;
    end
endmodule

module bsc_chain #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] SAFE_VAL = '0,
    parameter int               CNT_W    = 8,
    parameter logic [WIDTH-1:0] OUT_MASK = '0
) (
    input  logic             TCK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PI,
    input  logic             SI,
    input  logic             ShiftDR,
    input  logic             CaptureDR,
    input  logic             UpdateDR,
    input  logic             mode,
    output logic             SO,
    output logic [WIDTH-1:0] PO,
    output logic [CNT_W-1:0] ShiftCnt,
    output logic [WIDTH-1:0] c_q,
    output logic [WIDTH-1:0] u_q
);
    logic [WIDTH-1:0] cap_src;
    logic [WIDTH-1:0] ser_src;

    assign PO = mode ? u_q : PI;
    assign SO = c_q[0];

`ifdef BSC_CAPTURE_PO_EN
    // Masked cells observe the value actually driven onto the pin.
    assign cap_src = (OUT_MASK & PO) | (~OUT_MASK & PI);
`else
    assign cap_src = PI;
    if (OUT_MASK != '0) begin : g_out_mask_unused
        // OUT_MASK only matters when PO capture is built in.
    end
`endif

    assign ser_src = {SI, c_q[WIDTH-1:1]};

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        bsc_cell #(.SAFE(SAFE_VAL[k])) u_cell (
            .clk    (TCK),
            .rst    (RST),
            .cap    (CaptureDR),
            .shift  (ShiftDR),
            .upd    (UpdateDR),
            .cap_d  (cap_src[k]),
            .ser_in (ser_src[k]),
            .c      (c_q[k]),
            .u      (u_q[k])
        );
    end

    // Counter restarts on capture and sticks at all-ones instead of wrapping.
    always_ff @(posedge TCK) begin
        if (RST)
            ShiftCnt <= '0;
        else if (CaptureDR)
            ShiftCnt <= '0;
        else if (ShiftDR && (ShiftCnt != {CNT_W{1'b1}}))
            ShiftCnt <= ShiftCnt + 1'b1;
    end
endmodule
